fifo_dac_spi_tx: RTL and testbench
==================================

FIFO_DAC_SPI_TX -- requirements
Module: fifo_dac_spi_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default fifo_defines_pkg::DATA_WIDTH (16), meaning sample width and SPI frame length in bits.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period; legal range is 1 to 255.
REQ-003 The block SHALL have parameter CS_GAP, default 2, meaning the minimum number of clk cycles cs_n_o stays high between frames; legal range is 1 to 15.
REQ-004 The ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en_i  in  1  high allows new frames to start.
- fifo_empty_i  in  1  high when the upstream sample FIFO is empty.
- fifo_data_i  in  DATA_WIDTH  FIFO read data; valid on the clk cycle after fifo_rd_o is high.
- fifo_rd_o  out  1  single-cycle FIFO pop request.
- sclk_o  out  1  SPI clock, mode 0 (idles low).
- mosi_o  out  1  SPI data, MSB first.
- cs_n_o  out  1  DAC chip select, active low.
- busy_o  out  1  high in every state except IDLE.
- frame_cnt_o  out  16  count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-005 The block SHALL implement an FSM with states IDLE, FETCH, LOAD, SHIFT and GAP.
REQ-006 IDLE: when en_i is high and fifo_empty_i is low, the FSM SHALL assert fifo_rd_o for exactly one cycle and go to FETCH; otherwise it SHALL stay in IDLE.
REQ-007 FETCH: the FSM SHALL capture fifo_data_i into the shift register, then go to LOAD on the next cycle.
REQ-008 LOAD: the FSM SHALL drive cs_n_o low and mosi_o to the shift register MSB, start the divider, and go to SHIFT.
REQ-009 SHIFT: sclk_o SHALL toggle every CLK_DIV clk cycles; mosi_o SHALL change only on sclk_o falling edges; after DATA_WIDTH rising edges and the following falling edge, the FSM SHALL go to GAP.
REQ-010 A frame SHALL last exactly DATA_WIDTH*2*CLK_DIV clk cycles with cs_n_o low.
REQ-011 GAP: cs_n_o SHALL be high for CS_GAP cycles and frame_cnt_o SHALL increment by 1 on GAP entry; the FSM SHALL then go to IDLE.
REQ-012 fifo_rd_o SHALL never be asserted while fifo_empty_i is high, and SHALL never be asserted outside IDLE.
REQ-013 If en_i falls mid-frame, the current frame SHALL complete normally and no new frame SHALL start.
REQ-014 An empty FIFO in IDLE SHALL hold the FSM in IDLE with cs_n_o high and sclk_o low; there is no underrun error.

Reset
REQ-015 While rst is high, the block SHALL hold the FSM in IDLE and drive cs_n_o=1, sclk_o=0, mosi_o=0, fifo_rd_o=0, busy_o=0, frame_cnt_o=0, with the shift register and divider cleared.
REQ-016 If rst asserts mid-frame, the frame SHALL be aborted immediately and frame_cnt_o SHALL not increment.

Configuration
REQ-017 Macro DAC_OFFSET_BINARY_EN SHALL control sample encoding:
- Defined: the MSB of fifo_data_i SHALL be inverted when captured in FETCH (two's complement to offset binary).
- Undefined: fifo_data_i SHALL be shifted out unmodified.

Structure
REQ-018 fifo_defines_pkg SHALL hold the dac_state_t enum and the CLK_DIV and CS_GAP defaults; DATA_WIDTH SHALL be reused from the package.
REQ-019 The SCLK divider and edge-pulse generator SHALL be a single sub-module, dac_sclk_div, that outputs rise and fall tick pulses.

Verification
REQ-020 The bench SHALL cover, with DATA_WIDTH=16, CLK_DIV=2 and CS_GAP=2:
- One sample 0xA5C3 in the FIFO, en_i=1 -> one fifo_rd_o pulse; cs_n_o low for 64 cycles; bits 1010010111000011 sampled on sclk_o rising edges; frame_cnt_o=1.
- DAC_OFFSET_BINARY_EN defined, sample 0x8000 -> bits shifted out equal 0x0000.
- Three samples back-to-back -> three frames, each separated by at least 2 cycles of cs_n_o high; frame_cnt_o=3; the FIFO ends empty.
- fifo_empty_i=1 for 100 cycles -> fifo_rd_o, cs_n_o and sclk_o do not change.
- rst pulsed at cycle 20 of a frame -> cs_n_o=1 and sclk_o=0 immediately; frame_cnt_o stays 0.
- en_i dropped at cycle 10 of a frame with 2 samples queued -> the current frame completes, the second sample is not read, busy_o returns to 0.

Source files
------------

// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the FIFO-fed DAC SPI transmitter: default sizing and FSM state type.
package fifo_defines_pkg;

  localparam int unsigned DATA_WIDTH      = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 2;
  localparam int unsigned CS_GAP_DEFAULT  = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    GAP
  } dac_state_t;

endpackage

// File: rtl/dac_sclk_div.sv
// SPI clock divider: while enabled, toggles SCLK every CLK_DIV clk cycles and emits
// single-cycle rise/fall ticks in the cycle before the corresponding SCLK edge.
// Disabling clears the counter and parks SCLK low.
module dac_sclk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));

  // Half-period counter and SCLK level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Edge ticks decoded from the pending toggle direction
  always_comb begin
    o_sclk = r_sclk;
    o_rise = w_tick && !r_sclk;
    o_fall = w_tick && r_sclk;
  end

endmodule

// File: rtl/fifo_dac_spi_tx.sv
// FIFO-fed SPI transmitter for a DAC (mode 0, MSB first, one sample per frame).
// Optional build macro DAC_OFFSET_BINARY_EN: invert the sample MSB on capture
// (two's complement to offset binary); undefined sends samples unmodified.
module fifo_dac_spi_tx #(
  parameter int unsigned DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
  parameter int unsigned CLK_DIV    = fifo_defines_pkg::CLK_DIV_DEFAULT,
  parameter int unsigned CS_GAP     = fifo_defines_pkg::CS_GAP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  cs_n_o,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o
);

  import fifo_defines_pkg::*;

  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

  dac_state_t            r_state;
  dac_state_t            w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_sample;
  logic [BCW-1:0]        r_bit_cnt;
  logic [3:0]            r_gap_cnt;
  logic [15:0]           r_frame_cnt;
  logic                  w_div_en;
  logic                  w_sclk;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_last;
  logic                  w_gap_done;

`ifdef DAC_OFFSET_BINARY_EN
  assign w_sample = {~fifo_data_i[DATA_WIDTH-1], fifo_data_i[DATA_WIDTH-2:0]};
`else
  assign w_sample = fifo_data_i;
`endif

  // The divider runs from LOAD so that LOAD counts as the first low half-period of SCLK
  assign w_div_en   = (r_state == LOAD) || (r_state == SHIFT);
  assign w_last     = w_fall && (r_bit_cnt == BCW'(DATA_WIDTH));
  assign w_gap_done = (r_gap_cnt == 4'(CS_GAP - 1));

  dac_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_div_en),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en_i && !fifo_empty_i) w_next = FETCH;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_last) w_next = GAP;
      GAP:     if (w_gap_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    fifo_rd_o   = (r_state == IDLE) && en_i && !fifo_empty_i && !rst;
    cs_n_o      = !w_div_en;
    mosi_o      = w_div_en ? r_shift[DATA_WIDTH-1] : 1'b0;
    sclk_o      = w_sclk;
    busy_o      = (r_state != IDLE);
    frame_cnt_o = r_frame_cnt;
  end

  // Shift register: load in FETCH, advance on SCLK falling edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_shift <= '0;
    else if (r_state == FETCH)           r_shift <= w_sample;
    else if (r_state == SHIFT && w_fall) r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
  end

  // Rising-edge count within the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_bit_cnt <= '0;
    else if (!w_div_en)     r_bit_cnt <= '0;
    else if (w_rise)        r_bit_cnt <= r_bit_cnt + BCW'(1);
  end

  // Chip-select gap timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_gap_cnt <= '0;
    else if (r_state != GAP) r_gap_cnt <= '0;
    else                     r_gap_cnt <= r_gap_cnt + 4'd1;
  end

  // Completed-frame counter, bumped on GAP entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_frame_cnt <= '0;
    else if (r_state == SHIFT && w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fifo_dac_spi_tx.sv
// Testbench for fifo_dac_spi_tx: timeline model of frame timing plus directed scenarios.
module tb_fifo_dac_spi_tx;

  localparam int DW = 16;
  localparam int CD = 2;
  localparam int CG = 2;
  localparam int F  = DW * 2 * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_rd_o;
  logic          sclk_o;
  logic          mosi_o;
  logic          cs_n_o;
  logic          busy_o;
  logic [15:0]   frame_cnt_o;

  fifo_dac_spi_tx #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CD),
    .CS_GAP     (CG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (fifo_rd_o),
    .sclk_o       (sclk_o),
    .mosi_o       (mosi_o),
    .cs_n_o       (cs_n_o),
    .busy_o       (busy_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO model
  logic [DW-1:0] fq[$];
  logic          pend_pop = 1'b0;

  // Statistics gathered by the monitor
  int rd_pulses, cs_low_cyc, hi_run, min_gap;
  bit seen_frame;
  logic prev_cs = 1'b1;
  logic [DW-1:0] cap = '0;

  // Timeline model: m_t counts clk cycles since the FIFO read, -1 when idle
  int            m_t = -1;
  logic [15:0]   m_cnt = '0;
  logic [DW-1:0] m_sample = '0;

  function automatic logic [DW-1:0] encode(input logic [DW-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
    return s ^ (DW'(1) << (DW - 1));
`else
    return s;
`endif
  endfunction

  always @(posedge sclk_o) cap = {cap[DW-2:0], mosi_o};

  always @(negedge clk) begin
    logic e_rd, e_busy, e_cs, e_sclk, e_mosi;
    logic [DW-1:0] enc;
    int k;
    if (rst) begin
      m_t = -1;
      m_cnt = '0;
      pend_pop = 1'b0;
    end else begin
      if (m_t >= 0) begin
        m_t++;
        if (m_t == 2 + F) m_cnt++;
        if (m_t == 2 + F + CG) m_t = -1;
      end
      if (m_t < 0 && en_i && !fifo_empty_i) begin
        m_t = 0;
        m_sample = fq[0];
      end
    end
    e_rd   = (m_t == 0);
    e_busy = (m_t >= 1);
    e_cs   = !(m_t >= 2 && m_t < 2 + F);
    e_sclk = 1'b0;
    e_mosi = 1'b0;
    if (!e_cs) begin
      k = m_t - 2;
      enc = encode(m_sample);
      e_sclk = ((k / CD) % 2) == 1;
      e_mosi = enc[DW - 1 - k / (2 * CD)];
    end
    check("rd",    32'(fifo_rd_o),   32'(e_rd));
    check("busy",  32'(busy_o),      32'(e_busy));
    check("cs_n",  32'(cs_n_o),      32'(e_cs));
    check("sclk",  32'(sclk_o),      32'(e_sclk));
    check("mosi",  32'(mosi_o),      32'(e_mosi));
    check("count", 32'(frame_cnt_o), 32'(m_cnt));

    if (fifo_rd_o) rd_pulses++;
    if (!cs_n_o) cs_low_cyc++;
    if (cs_n_o) hi_run++;
    else begin
      if (prev_cs && seen_frame && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
      seen_frame = 1'b1;
    end
    prev_cs = cs_n_o;

    if (pend_pop && fq.size() > 0) begin
      fifo_data_i = fq.pop_front();
      fifo_empty_i = (fq.size() == 0);
    end
    pend_pop = fifo_rd_o && !rst;
  end

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
    fifo_empty_i = 1'b0;
  endtask

  task automatic clear_stats();
    rd_pulses = 0; cs_low_cyc = 0; hi_run = 0; min_gap = 1000; seen_frame = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_i = 1'b0;
    fq.delete();
    fifo_empty_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (frame_cnt_o >= 16'(n)) break;
    end
    check("frames_reached", 32'(frame_cnt_o), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy_o) break;
    end
    check("idle_reached", 32'(busy_o), 32'd0);
  endtask

  task automatic wait_cs_low(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!cs_n_o) break;
    end
    check("frame_started", 32'(cs_n_o), 32'd0);
  endtask

  logic [DW-1:0] exp_8000;
  int bad;

  initial begin
    rst = 1'b1; en_i = 1'b0; fifo_empty_i = 1'b1; fifo_data_i = '0;
    clear_stats();
    repeat (3) @(posedge clk); #1;
    check("rst_cs_n",  32'(cs_n_o),      32'd1);
    check("rst_sclk",  32'(sclk_o),      32'd0);
    check("rst_mosi",  32'(mosi_o),      32'd0);
    check("rst_rd",    32'(fifo_rd_o),   32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_count", 32'(frame_cnt_o), 32'd0);
    rst = 1'b0;

    // Single sample 0xA5C3
    clear_stats();
    push(16'hA5C3); en_i = 1'b1;
    wait_frames(1, 400);
    wait_idle(100);
    check("t1_bits",      32'(cap),   32'h0000A5C3);
    check("t1_rd_pulses", rd_pulses,  1);
    check("t1_cs_low",    cs_low_cyc, 64);
    check("t1_count",     32'(frame_cnt_o), 32'd1);

    // 0x8000 sample: encoding depends on build option
`ifdef DAC_OFFSET_BINARY_EN
    exp_8000 = 16'h0000;
`else
    exp_8000 = 16'h8000;
`endif
    do_reset();
    cap = 16'hFFFF;
    push(16'h8000); en_i = 1'b1;
    wait_frames(1, 400);
    wait_idle(100);
    check("t2_bits", 32'(cap), 32'(exp_8000));

    // Three back-to-back samples
    do_reset();
    push(16'h1234); push(16'hFEDC); push(16'h0F0F); en_i = 1'b1;
    wait_frames(3, 1000);
    wait_idle(100);
    check("t3_count",     32'(frame_cnt_o), 32'd3);
    check("t3_rd_pulses", rd_pulses, 3);
    check("t3_gap_ge_2",  32'(min_gap >= 2 && min_gap < 1000), 32'd1);
    check("t3_fifo_left", fq.size(), 0);
    check("t3_empty",     32'(fifo_empty_i), 32'd1);
    check("t3_last_bits", 32'(cap), 32'(encode(16'h0F0F)));

    // Empty FIFO held for 100 cycles
    do_reset();
    en_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (fifo_rd_o !== 1'b0 || cs_n_o !== 1'b1 || sclk_o !== 1'b0) bad++;
    end
    check("t4_empty_hold", bad, 0);

    // Reset mid-frame
    do_reset();
    push(16'h5A5A); en_i = 1'b1;
    wait_cs_low(50);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_cs_n_now", 32'(cs_n_o), 32'd1);
    check("t5_sclk_now", 32'(sclk_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 en_i = 1'b0; rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("t5_count", 32'(frame_cnt_o), 32'd0);
    check("t5_busy",  32'(busy_o),      32'd0);

    // Enable dropped mid-frame with two samples queued
    do_reset();
    push(16'hC001); push(16'h7777); en_i = 1'b1;
    wait_cs_low(50);
    repeat (9) @(posedge clk);
    #1 en_i = 1'b0;
    wait_idle(200);
    repeat (30) @(posedge clk); #1;
    check("t6_busy",      32'(busy_o),      32'd0);
    check("t6_count",     32'(frame_cnt_o), 32'd1);
    check("t6_rd_pulses", rd_pulses, 1);
    check("t6_fifo_left", fq.size(), 1);
    check("t6_bits",      32'(cap), 32'(encode(16'hC001)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
